// File: rtl/bla_subtractor_seq_pkg.sv
// Shared types for the sequential borrow-lookahead subtractor.
// Holds the controller state encoding and the slice width.
package bla_subtractor_seq_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/bla_slice4.sv
// 4-bit borrow-lookahead subtract slice: d = a - b - bin, bout = borrow out.
// Combinational, zero latency; no flow control.
module bla_slice4
  import bla_subtractor_seq_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               bin,
  output logic [SLICE_W-1:0] d,
  output logic               bout
);

  logic [SLICE_W-1:0] g;
  logic [SLICE_W-1:0] p;
  logic [SLICE_W:0]   br;

  assign g = ~a & b;
  assign p = ~(a ^ b);

  // Every borrow is a sum of products of g/p and bin, so no bit waits on its neighbour.
  assign br[0] = bin;
  assign br[1] = g[0] | (p[0] & bin);
  assign br[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bin);
  assign br[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & bin);
  assign br[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & bin);

  assign d    = a ^ b ^ br[SLICE_W-1:0];
  assign bout = br[SLICE_W];

endmodule

// File: rtl/bla_subtractor_seq.sv
// Multi-cycle subtractor: diff = a - b - bin, one 4-bit lookahead slice per clock, LSB first.
// Latency: out_valid rises WIDTH/4 cycles after the accept edge.
// Backpressure: result held in DONE until out_ready; operands accepted only in IDLE.
module bla_subtractor_seq
  import bla_subtractor_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [KW-1:0] KLAST = KW'(NSLICE - 1);

  state_t             state;
  state_t             state_nxt;
  logic [KW-1:0]      k;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic               br_r;
  logic [SLICE_W-1:0] sl_d;
  logic               sl_bout;
  logic               accept;
  logic               last;

  assign accept = in_valid & in_ready;
  assign last   = (k == KLAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  bla_slice4 u_slice (
    .a    (a_r[k*SLICE_W +: SLICE_W]),
    .b    (b_r[k*SLICE_W +: SLICE_W]),
    .bin  (br_r),
    .d    (sl_d),
    .bout (sl_bout)
  );

  // diff/bout/ovf are only rewritten while a new operation runs; DONE holds them untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k    <= '0;
      a_r  <= '0;
      b_r  <= '0;
      br_r <= 1'b0;
      diff <= '0;
      bout <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_r  <= a;
            b_r  <= b;
            br_r <= bin;
            k    <= '0;
          end
        end
        RUN: begin
          diff[k*SLICE_W +: SLICE_W] <= sl_d;
          br_r <= sl_bout;
          if (last) begin
            k    <= '0;
            bout <= sl_bout;
            ovf  <= (a_r[WIDTH-1] ^ b_r[WIDTH-1]) & (sl_d[SLICE_W-1] ^ a_r[WIDTH-1]);
          end else begin
            k <= k + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bla_subtractor_seq.sv
// Directed and model-checked bench for bla_subtractor_seq at WIDTH = 16.
module tb_bla_subtractor_seq;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         bout;
  logic         ovf;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bla_subtractor_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present operands for one accept edge, then wait (bounded) for out_valid.
  task automatic launch(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin,
                        output int lat);
    a = ta; b = tb; bin = tbin; in_valid = 1'b1;
    chk("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("in_ready_after_accept", {31'd0, in_ready}, 32'd0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic finish_op(input string tag, input logic [W-1:0] ed, input logic eb, input logic eo);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_diff"}, {16'd0, diff}, {16'd0, ed});
    chk({tag, "_bout"}, {31'd0, bout}, {31'd0, eb});
    chk({tag, "_ovf"}, {31'd0, ovf}, {31'd0, eo});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_out_valid_drop"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_in_ready_back"}, {31'd0, in_ready}, 32'd1);
  endtask

  task automatic do_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                       input logic tbin, input logic [W-1:0] ed, input logic eb, input logic eo);
    int lat;
    launch(ta, tb, tbin, lat);
    chk({tag, "_latency"}, lat, 32'd4);
    finish_op(tag, ed, eb, eo);
  endtask

  initial begin
    int lat;
    int nacc;
    int nres;
    bit acc;
    bit seen;
    logic [W-1:0] rd [2];
    logic         rb [2];
    logic [W-1:0] ra, rbv, ed;
    logic         rbin, eb, eo;
    logic [W:0]   wide;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; bin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_diff", {16'd0, diff}, 32'd0);
    chk("rst_bout", {31'd0, bout}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Basic, wrap-around and signed-overflow cases.
    do_op("t1", 16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0);
    do_op("t2a", 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
    do_op("t2b", 16'h8000, 16'h7FFF, 1'b1, 16'h0000, 1'b0, 1'b1);
    do_op("eq", 16'hA5A5, 16'hA5A5, 1'b0, 16'h0000, 1'b0, 1'b0);
    do_op("zero_bin", 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    do_op("neg_ovf", 16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1);

    // Backpressure: result held for 10 cycles while new operands are offered.
    launch(16'h4321, 16'h1111, 1'b1, lat);
    chk("bp_latency", lat, 32'd4);
    a = 16'hFFFF; b = 16'h0001; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_diff", {16'd0, diff}, 32'h320F);
      chk("bp_bout", {31'd0, bout}, 32'd0);
      chk("bp_ovf", {31'd0, ovf}, 32'd0);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_release", {31'd0, out_valid}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    chk("bp_single_handshake", {31'd0, seen}, 32'd0);

    // Back-to-back with in_valid held high and out_ready always high.
    a = 16'h00FF; b = 16'h0F00; bin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    nacc = 0; nres = 0; seen = 1'b0;
    for (int i = 0; i < 30 && nres < 2; i++) begin
      acc = in_valid & in_ready;
      if (out_valid && in_ready) seen = 1'b1;
      if (out_valid) begin
        rd[nres] = diff;
        rb[nres] = bout;
        nres++;
      end
      tick();
      if (acc) begin
        nacc++;
        if (nacc == 1) begin a = 16'hFFFF; b = 16'hFFFF; end
        else in_valid = 1'b0;
      end
    end
    out_ready = 1'b0;
    in_valid = 1'b0;
    chk("b2b_results", nres, 32'd2);
    chk("b2b_accepts", nacc, 32'd2);
    chk("b2b_no_overlap", {31'd0, seen}, 32'd0);
    chk("b2b_diff0", {16'd0, rd[0]}, 32'hF1FF);
    chk("b2b_bout0", {31'd0, rb[0]}, 32'd1);
    chk("b2b_diff1", {16'd0, rd[1]}, 32'h0000);
    chk("b2b_bout1", {31'd0, rb[1]}, 32'd0);
    tick();

    // Reset asserted during the third RUN cycle aborts the operation.
    a = 16'h9999; b = 16'h1111; bin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #2;
    chk("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_mid_diff", {16'd0, diff}, 32'd0);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid || !in_ready) seen = 1'b1;
    end
    chk("rst_mid_no_result", {31'd0, seen}, 32'd0);
    do_op("post_rst", 16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0);

    // Random sweep against a wide-subtraction reference.
    for (int i = 0; i < 1000; i++) begin
      ra   = W'($urandom);
      rbv  = W'($urandom);
      rbin = 1'($urandom_range(0, 1));
      wide = {1'b0, ra} - {1'b0, rbv} - {{W{1'b0}}, rbin};
      ed   = wide[W-1:0];
      eb   = wide[W];
      eo   = (ra[W-1] != rbv[W-1]) && (ed[W-1] != ra[W-1]);
      do_op("rand", ra, rbv, rbin, ed, eb, eo);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
